// File: rtl/xain_pkg.sv
// Shared types and widths for the bridge-to-ioctl download path.
package xain_pkg;

    localparam int unsigned IOCTL_ADDR_W = 25;
    localparam int unsigned IOCTL_DATA_W = 8;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned SLOT_W       = 16;
    localparam int unsigned FIFO_ENTRY_W = IOCTL_ADDR_W + WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT,
        GAP,
        FINISH
    } ser_state_t;

    // One buffered bridge word: byte address (low two bits unused) and payload.
    typedef struct packed {
        logic [IOCTL_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]       data;
    } fifo_entry_t;

endpackage

// File: rtl/ioctl_word_fifo.sv
// Synchronous word FIFO with flush; count, full and empty are registered.
module ioctl_word_fifo
    import xain_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic                            pop,
    input  fifo_entry_t                     wdata,
    output fifo_entry_t                     rdata,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               do_push;
    logic               do_pop;

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/bridge_ioctl_serializer.sv
// Turns buffered 32-bit bridge words into a big-endian ioctl byte stream
// with fixed write spacing, ioctl_wait back-pressure and download framing.
module bridge_ioctl_serializer
    import xain_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WRITE_GAP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dl_start,
    input  logic [SLOT_W-1:0]        dl_slot,
    input  logic                     dl_end,
    input  logic                     word_wr,
    input  logic [IOCTL_ADDR_W-1:0]  word_addr,
    input  logic [WORD_W-1:0]        word_data,
    output logic                     word_full,
    output logic                     overflow,
    output logic                     ioctl_download,
    output logic [SLOT_W-1:0]        ioctl_index,
    output logic                     ioctl_wr,
    output logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
    output logic [IOCTL_DATA_W-1:0]  ioctl_data,
    input  logic                     ioctl_wait
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GAP_W      = $clog2(WRITE_GAP);
    localparam logic [IOCTL_ADDR_W-1:0] ADDR_WORD_MASK = ~IOCTL_ADDR_W'(3);

    ser_state_t              state;
    fifo_entry_t             fifo_wdata;
    fifo_entry_t             fifo_rdata;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    fifo_empty;
    logic                    push_c;
    logic                    pop_c;
    logic                    last_gap_c;
    logic                    end_flag;
    logic [WORD_W-1:0]       shreg;
    logic [IOCTL_ADDR_W-1:0] cur_addr;
    logic [1:0]              byte_idx;
    logic [GAP_W-1:0]        gap_cnt;

    // The last gap cycle after byte 3 doubles as FETCH so word-to-word spacing stays WRITE_GAP.
    assign last_gap_c = (state == GAP) && (gap_cnt == '0);
    assign push_c     = word_wr && (state != IDLE) && !dl_start;
    assign pop_c      = !dl_start &&
                        ((state == FETCH) || (last_gap_c && (byte_idx == 2'd3)));
    assign fifo_wdata = '{addr: word_addr, data: word_data};

    ioctl_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (dl_start),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (word_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            overflow       <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_data     <= '0;
            end_flag       <= 1'b0;
            shreg          <= '0;
            cur_addr       <= '0;
            byte_idx       <= 2'd0;
            gap_cnt        <= '0;
        end else begin
            ioctl_wr <= 1'b0;
            if ((state != IDLE) && word_wr && word_full) begin
                overflow <= 1'b1;
            end
            if (dl_end) begin
                end_flag <= 1'b1;
            end

            // A start always wins: relatch, clear, and abandon whatever was in flight.
            if (dl_start) begin
                ioctl_index    <= dl_slot;
                overflow       <= 1'b0;
                end_flag       <= 1'b0;
                ioctl_download <= 1'b1;
                state          <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        ioctl_download <= 1'b0;
                    end
                    FETCH: begin
                        if (fifo_count != '0) begin
                            shreg    <= fifo_rdata.data;
                            cur_addr <= fifo_rdata.addr;
                            byte_idx <= 2'd0;
                            state    <= EMIT;
                        end else if (end_flag) begin
                            state <= FINISH;
                        end
                    end
                    EMIT: begin
                        if (!ioctl_wait) begin
                            ioctl_wr   <= 1'b1;
                            ioctl_data <= shreg[WORD_W-1 -: IOCTL_DATA_W];
                            ioctl_addr <= (cur_addr & ADDR_WORD_MASK) | IOCTL_ADDR_W'(byte_idx);
                            shreg      <= {shreg[WORD_W-IOCTL_DATA_W-1:0], IOCTL_DATA_W'(0)};
                            gap_cnt    <= GAP_W'(WRITE_GAP - 2);
                            state      <= GAP;
                        end
                    end
                    GAP: begin
                        if (!last_gap_c) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= EMIT;
                        end else if (!fifo_empty) begin
                            shreg    <= fifo_rdata.data;
                            cur_addr <= fifo_rdata.addr;
                            byte_idx <= 2'd0;
                            state    <= EMIT;
                        end else begin
                            state <= FETCH;
                        end
                    end
                    FINISH: begin
                        ioctl_download <= 1'b0;
                        state          <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bridge_ioctl_serializer.sv
// Directed bench for bridge_ioctl_serializer with hand-computed byte timing.
module tb_bridge_ioctl_serializer;

    localparam int unsigned G     = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_start;
    logic [15:0] dl_slot;
    logic        dl_end;
    logic        word_wr;
    logic [24:0] word_addr;
    logic [31:0] word_data;
    logic        word_full;
    logic        overflow;
    logic        ioctl_download;
    logic [15:0] ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;

    bridge_ioctl_serializer #(
        .FIFO_DEPTH (DEPTH),
        .WRITE_GAP  (G)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dl_start       (dl_start),
        .dl_slot        (dl_slot),
        .dl_end         (dl_end),
        .word_wr        (word_wr),
        .word_addr      (word_addr),
        .word_data      (word_data),
        .word_full      (word_full),
        .overflow       (overflow),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          log_cyc[$];
    logic [24:0] log_addr[$];
    logic [7:0]  log_data[$];
    bit          dl_prev = 1'b0;
    bit          fall_seen = 1'b0;
    int          fall_cyc = 0;
    int          total = 0;
    int          bad = 0;

    // Byte and download-edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ioctl_wr) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(ioctl_addr);
            log_data.push_back(ioctl_data);
        end
        if (dl_prev && !ioctl_download) begin
            fall_seen = 1'b1;
            fall_cyc  = cyc;
        end
        dl_prev = ioctl_download;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
        fall_seen = 1'b0;
    endtask

    task automatic start_dl(input logic [15:0] slot);
        dl_slot  = slot;
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
    endtask

    task automatic send_word(input logic [24:0] a, input logic [31:0] d, output int t);
        t         = cyc + 1;
        word_wr   = 1'b1;
        word_addr = a;
        word_data = d;
        tick();
        word_wr   = 1'b0;
    endtask

    task automatic end_dl();
        dl_end = 1'b1;
        tick();
        dl_end = 1'b0;
    endtask

    task automatic wait_fall(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fall_seen) break;
            tick();
        end
        chk({tag, "_fall_seen"}, 32'(fall_seen), 32'd1);
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        byte_of = w[31-8*k -: 8];
    endfunction

    task automatic check_byte(input string tag, input int idx, input int exp_cyc,
                              input logic [24:0] exp_addr, input logic [7:0] exp_data);
        if (idx < log_cyc.size()) begin
            chk($sformatf("%s_b%0d_cyc", tag, idx), 32'(log_cyc[idx]), 32'(exp_cyc));
            chk($sformatf("%s_b%0d_addr", tag, idx), 32'(log_addr[idx]), 32'(exp_addr));
            chk($sformatf("%s_b%0d_data", tag, idx), 32'(log_data[idx]), 32'(exp_data));
        end else begin
            chk($sformatf("%s_b%0d_missing", tag, idx), 32'(log_cyc.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_download"}, 32'(ioctl_download), 32'd0);
        chk({tag, "_index"},    32'(ioctl_index),    32'd0);
        chk({tag, "_wr"},       32'(ioctl_wr),       32'd0);
        chk({tag, "_addr"},     32'(ioctl_addr),     32'd0);
        chk({tag, "_data"},     32'(ioctl_data),     32'd0);
        chk({tag, "_full"},     32'(word_full),      32'd0);
        chk({tag, "_ovf"},      32'(overflow),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        logic [31:0] w;

        reset = 1'b1; dl_start = 1'b0; dl_slot = '0; dl_end = 1'b0;
        word_wr = 1'b0; word_addr = '0; word_data = '0; ioctl_wait = 1'b0;
        repeat (3) tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // Single word, no back-pressure.
        clear_log();
        start_dl(16'h0000);
        chk("t1_download", 32'(ioctl_download), 32'd1);
        send_word(25'h000100, 32'h11223344, t);
        end_dl();
        wait_fall("t1", 60);
        chk("t1_nbytes", 32'(log_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check_byte("t1", k, t + 2 + 4 * k, 25'h000100 + 25'(k), byte_of(32'h11223344, k));
        chk("t1_fall_cyc", 32'(fall_cyc), 32'(t + 19));

        // Same word, ioctl_wait held for 10 cycles over the second byte.
        clear_log();
        start_dl(16'h0042);
        send_word(25'h000100, 32'h11223344, t);
        end_dl();
        while (cyc < t + 5) tick();
        ioctl_wait = 1'b1;
        repeat (10) tick();
        ioctl_wait = 1'b0;
        wait_fall("t2", 60);
        chk("t2_nbytes", 32'(log_cyc.size()), 32'd4);
        check_byte("t2", 0, t + 2,  25'h000100, 8'h11);
        check_byte("t2", 1, t + 16, 25'h000101, 8'h22);
        check_byte("t2", 2, t + 20, 25'h000102, 8'h33);
        check_byte("t2", 3, t + 24, 25'h000103, 8'h44);
        chk("t2_fall_cyc", 32'(fall_cyc), 32'(t + 29));
        chk("t2_index_held", 32'(ioctl_index), 32'h0042);

        // Six back-to-back words into a four-deep FIFO.
        clear_log();
        start_dl(16'h0003);
        t = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            word_wr   = 1'b1;
            word_addr = 25'h000200 + 25'(4 * k);
            word_data = {8'(16 * k + 1), 8'(16 * k + 2), 8'(16 * k + 3), 8'(16 * k + 4)};
            tick();
            if (k == 3) chk("t3_full_k3", 32'(word_full), 32'd0);
            if (k == 4) chk("t3_full_k4", 32'(word_full), 32'd1);
            if (k == 4) chk("t3_ovf_k4", 32'(overflow), 32'd0);
            if (k == 5) chk("t3_ovf_k5", 32'(overflow), 32'd1);
        end
        word_wr = 1'b0;
        end_dl();
        wait_fall("t3", 200);
        chk("t3_nbytes", 32'(log_cyc.size()), 32'd20);
        for (int n = 0; n < 20; n++)
            check_byte("t3", n, t + 2 + 4 * n, 25'h000200 + 25'(n), 8'(16 * (n / 4) + 1 + (n % 4)));
        chk("t3_fall_cyc", 32'(fall_cyc), 32'(t + 83));
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Restart after two bytes of word A; fillers also overflow the FIFO first.
        clear_log();
        start_dl(16'h0005);
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        t = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            word_wr   = 1'b1;
            word_addr = (k == 0) ? 25'h000300 : 25'h000700 + 25'(4 * k);
            word_data = (k == 0) ? 32'hAABBCCDD : 32'hEE000000 + 32'(k);
            tick();
        end
        word_wr = 1'b0;
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        while (cyc < t + 7) tick();
        start_dl(16'h0006);
        chk("t4_ovf_restart", 32'(overflow), 32'd0);
        chk("t4_index", 32'(ioctl_index), 32'h0006);
        chk("t4_full", 32'(word_full), 32'd0);
        chk("t4_download", 32'(ioctl_download), 32'd1);
        send_word(25'h000400, 32'h55667788, t2);
        end_dl();
        wait_fall("t4", 80);
        chk("t4_nbytes", 32'(log_cyc.size()), 32'd6);
        check_byte("t4a", 0, t + 2, 25'h000300, 8'hAA);
        check_byte("t4a", 1, t + 6, 25'h000301, 8'hBB);
        for (int k = 0; k < 4; k++)
            check_byte("t4b", 2 + k, t2 + 2 + 4 * k, 25'h000400 + 25'(k), byte_of(32'h55667788, k));

        // Reset while EMIT is stalled, then a clean restart.
        clear_log();
        start_dl(16'h0007);
        send_word(25'h000500, 32'hCAFEF00D, t);
        ioctl_wait = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("t5_rst");
        reset = 1'b0;
        ioctl_wait = 1'b0;
        repeat (5) tick();
        chk("t5_no_bytes", 32'(log_cyc.size()), 32'd0);
        chk("t5_idle", 32'(ioctl_download), 32'd0);

        clear_log();
        dl_slot  = 16'h0008;
        dl_start = 1'b1;
        dl_end   = 1'b1;
        tick();
        dl_start = 1'b0;
        dl_end   = 1'b0;
        repeat (3) tick();
        chk("t5_end_ignored", 32'(ioctl_download), 32'd1);
        w = 32'h0F1E2D3C;
        send_word(25'h000600, w, t);
        end_dl();
        wait_fall("t5", 60);
        chk("t5_nbytes", 32'(log_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check_byte("t5", k, t + 2 + 4 * k, 25'h000600 + 25'(k), byte_of(w, k));
        chk("t5_fall_cyc", 32'(fall_cyc), 32'(t + 19));
        chk("t5_index", 32'(ioctl_index), 32'h0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
